axis2fifo: RTL and testbench
============================

Name: axis2fifo

Overview:
- AXI4-Stream slave front end for the output FIFO stage. Accepts 32-bit beats, buffers them internally and releases them downstream in fixed bursts of BURST_LEN words.
- Each burst is driven on dout/data_ready over consecutive cycles, one word per cycle, with no backpressure from the consumer.
- After each burst, a mandatory idle gap lets the consumer finish its read/flush phase.

Parameters:
- DATA_WIDTH, 32, width of tdata and dout.
- DEPTH, 8, buffer entries; must be a power of two and a multiple of BURST_LEN.
- BURST_LEN, 4, words per burst presented to the consumer.
- GAP_CYCLES, 6, idle cycles forced between bursts (consumer READ+WAIT time).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tlast  in  1  end of packet.
- s_axis_tready  out  1  stream ready.
- dout  out  DATA_WIDTH  registered burst word to the consumer.
- data_ready  out  1  high for exactly BURST_LEN consecutive cycles per burst; dout is valid while it is high.
- level  out  $clog2(DEPTH)+1  words currently stored.
- busy  out  1  read FSM not in IDLE.

Behaviour:
- Reset (sync, rst=1 at the clock edge): pointers=0, level=0, grp_cnt=0, read FSM=IDLE, write FSM=ACCEPT, dout=0, data_ready=0, busy=0. Memory contents are don't-care. Reset mid-burst aborts the burst immediately, and data_ready is 0 on the next cycle.
- Accept: s_axis_tready = (write FSM==ACCEPT) && (level<DEPTH), combinational from registers only. A beat is written when tvalid&&tready.
- grp_cnt (mod BURST_LEN) tracks words written in the current group; it increments on every write, including pad writes.
- Level update: +1 per write, -1 per burst word read. A simultaneous write and read leaves level unchanged. Level never exceeds DEPTH and never underflows.
- Read FSM, IDLE:
  - If level>=BURST_LEN at the edge: dout<=mem[rd_ptr], data_ready<=1, rd_ptr++, beat<=1, go to SEND.
  - Latency: the BURST_LEN-th word accepted at edge N gives the first burst word on dout after edge N+1.
- Read FSM, SEND:
  - Each edge: if beat<BURST_LEN, dout<=mem[rd_ptr], rd_ptr++, beat++.
  - Otherwise data_ready<=0, dout<=0, gap counter<=GAP_CYCLES-1, go to GAP.
- Read FSM, GAP:
  - Counter decrements each cycle; at 0, go to IDLE.
  - GAP_CYCLES=0 is legal: GAP lasts a single cycle.
  - Net effect: a minimum of GAP_CYCLES+1 cycles with data_ready=0 between bursts.
- Write side is independent of the read FSM: beats are accepted during SEND and GAP while space exists.
- Pointers wrap modulo DEPTH. Full (level==DEPTH) deasserts tready. Empty or level<BURST_LEN keeps the read FSM in IDLE indefinitely; partial groups are never emitted.
- Words are emitted in arrival order, with no loss and no duplication.

Optional Feature:
- Macro AXIS2FIFO_PAD_ON_TLAST_EN.
- Defined:
  - Write FSM has a PAD state. On an accepted beat with tlast=1, if grp_cnt after that write is not 0, go to PAD.
  - In PAD: tready=0; one zero word is written per cycle until grp_cnt returns to 0, then back to ACCEPT.
  - Space for the pad words is guaranteed because DEPTH is a multiple of BURST_LEN and reads remove whole groups. PAD still honours level<DEPTH.
- Undefined: tlast is ignored; the write FSM is always ACCEPT; partial groups wait for further beats.

Decomposition:
- Package axis2fifo_pkg holds:
  - read FSM state encoding: IDLE=2'b00, SEND=2'b01, GAP=2'b10;
  - write FSM encoding: ACCEPT, PAD;
  - default BURST_LEN and GAP_CYCLES constants shared with the consumer stage.
- One natural sub-module, axis2fifo_mem: a simple dual-port register array (DEPTH x DATA_WIDTH), with one synchronous write port and a combinational read port.

Test Plan:
- Reset, then 4 beats 0x11,0x22,0x33,0x44 with tvalid held high -> data_ready high for exactly 4 cycles starting 1 cycle after the 4th handshake, dout=0x11,0x22,0x33,0x44, then level=0 and busy falls after GAP_CYCLES+1 low cycles.
- Send 3 beats only -> data_ready stays 0 for 50 cycles and level=3; 4th beat 0xA4 -> burst emitted in order.
- Stream 12 beats back-to-back with tvalid always high -> tready drops when level=8; 3 bursts emitted; each pair of bursts separated by at least 7 data_ready-low cycles; no word lost.
- Assert rst on the 2nd cycle of a burst -> next cycle data_ready=0, dout=0, level=0, tready=1; fresh 4 beats then produce a clean burst.
- With AXIS2FIFO_PAD_ON_TLAST_EN defined: beats 0x1,0x2 with tlast on 0x2 -> tready low for 2 cycles, burst dout=0x1,0x2,0x0,0x0. Without the macro: no burst until 2 more beats arrive.
- Simultaneous write during SEND at level=4 -> level holds correctly (decrements by 1 per read only when no write is accepted that cycle) and read and write pointers wrap past 7 correctly.

Source files
------------

// File: rtl/axis2fifo_pkg.sv
// axis2fifo_pkg: shared constants for the AXI4-Stream to burst FIFO stage.
//   - Read FSM state encoding (IDLE/SEND/GAP) and write FSM encoding (ACCEPT/PAD).
//   - Default burst length and inter-burst gap, shared with the consumer stage.
//   - cnt_width(): bits needed to hold the values 0..max_val (at least 1).
package axis2fifo_pkg;

  localparam logic [1:0] RD_IDLE = 2'b00;
  localparam logic [1:0] RD_SEND = 2'b01;
  localparam logic [1:0] RD_GAP  = 2'b10;

  localparam logic [0:0] WR_ACCEPT = 1'b0;
  localparam logic [0:0] WR_PAD    = 1'b1;

  localparam int BURST_LEN_DEF  = 4;
  localparam int GAP_CYCLES_DEF = 6;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/axis2fifo_mem.sv
// axis2fifo_mem: DEPTH x DATA_WIDTH register array, one synchronous write
// port and one combinational read port. Contents are not reset.
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  mem[rd_addr], combinational
module axis2fifo_mem
  import axis2fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis2fifo.sv
// axis2fifo: AXI4-Stream slave that buffers beats and releases them to the
// consumer in fixed bursts of BURST_LEN words, one word per cycle, followed
// by at least GAP_CYCLES+1 idle cycles.
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   s_axis_tdata   in   stream data
//   s_axis_tvalid  in   stream valid
//   s_axis_tlast   in   end of packet (only used with AXIS2FIFO_PAD_ON_TLAST_EN)
//   s_axis_tready  out  stream ready
//   dout           out  registered burst word
//   data_ready     out  dout valid, high BURST_LEN consecutive cycles per burst
//   level          out  words currently stored
//   busy           out  read FSM not in IDLE
// Build option: define AXIS2FIFO_PAD_ON_TLAST_EN to zero-pad a partial group
// up to BURST_LEN words when a beat with tlast is accepted.
//
// Read FSM
//   state | meaning
//   IDLE  | waiting for a full group (level >= BURST_LEN)
//   SEND  | presenting burst words on dout, one per cycle
//   GAP   | forced idle time for the consumer's read/flush phase
// Write FSM
//   state  | meaning
//   ACCEPT | taking stream beats while space exists
//   PAD    | writing zero words until the current group is complete
module axis2fifo
  import axis2fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    data_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy
);

  localparam int PTR_W      = $clog2(DEPTH);
  localparam int LVL_W      = PTR_W + 1;
  localparam int GRP_W      = cnt_width(BURST_LEN - 1);
  localparam int BEAT_W     = cnt_width(BURST_LEN);
  localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int GAP_W      = cnt_width(GAP_LOAD_I);

  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_BURST = LVL_W'(BURST_LEN);
  localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_LOAD_I);

  logic [1:0]            rd_state;
  logic [0:0]            wr_state;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [GRP_W-1:0]      grp_cnt, grp_cnt_nxt;
  logic [BEAT_W-1:0]     beat;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  beat_wr, pad_wr, wr_en, rd_en, pad_start;
  logic [DATA_WIDTH-1:0] wr_data, mem_rd_data;

  assign s_axis_tready = (wr_state == WR_ACCEPT) && (level < LVL_FULL);
  assign beat_wr       = s_axis_tvalid && s_axis_tready;
  assign pad_wr        = (wr_state == WR_PAD) && (level < LVL_FULL);
  assign wr_en         = beat_wr || pad_wr;
  assign wr_data       = pad_wr ? '0 : s_axis_tdata;
  assign grp_cnt_nxt   = (grp_cnt == GRP_LAST) ? '0 : grp_cnt + 1'b1;

`ifdef AXIS2FIFO_PAD_ON_TLAST_EN
  assign pad_start = beat_wr && s_axis_tlast && (grp_cnt_nxt != '0);
`else
  logic tlast_unused;
  assign tlast_unused = s_axis_tlast;
  assign pad_start    = 1'b0;
`endif

  // Reads happen on the IDLE->SEND edge and on every SEND edge that still
  // has words left in the burst; level only moves when exactly one side acts.
  assign rd_en = ((rd_state == RD_IDLE) && (level >= LVL_BURST)) ||
                 ((rd_state == RD_SEND) && (beat < BEAT_LAST));

  assign busy = (rd_state != RD_IDLE);

  axis2fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_ACCEPT;
      wr_ptr   <= '0;
      grp_cnt  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr  <= wr_ptr + 1'b1;
        grp_cnt <= grp_cnt_nxt;
      end
      case (wr_state)
        WR_ACCEPT: if (pad_start) wr_state <= WR_PAD;
        WR_PAD:    if (pad_wr && (grp_cnt_nxt == '0)) wr_state <= WR_ACCEPT;
        default:   wr_state <= WR_ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state   <= RD_IDLE;
      rd_ptr     <= '0;
      beat       <= '0;
      gap_cnt    <= '0;
      dout       <= '0;
      data_ready <= 1'b0;
    end else begin
      if (rd_en) begin
        dout   <= mem_rd_data;
        rd_ptr <= rd_ptr + 1'b1;
      end
      case (rd_state)
        RD_IDLE: begin
          if (rd_en) begin
            data_ready <= 1'b1;
            beat       <= BEAT_W'(1);
            rd_state   <= RD_SEND;
          end
        end
        RD_SEND: begin
          if (rd_en) begin
            beat <= beat + 1'b1;
          end else begin
            data_ready <= 1'b0;
            dout       <= '0;
            gap_cnt    <= GAP_LOAD;
            rd_state   <= RD_GAP;
          end
        end
        RD_GAP: begin
          if (gap_cnt == '0) rd_state <= RD_IDLE;
          else               gap_cnt  <= gap_cnt - 1'b1;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis2fifo.sv
// tb_axis2fifo: directed bench for axis2fifo with default parameters
// (DEPTH 8, BURST_LEN 4, GAP_CYCLES 6). Inputs change 1 ns after the rising
// edge and outputs are read at that point; a negedge monitor logs burst words
// and the lengths of data_ready high/low runs.
module tb_axis2fifo;

  localparam int GAP = 6;

  logic        clk;
  logic        rst;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] dout;
  logic        data_ready;
  logic [3:0]  level;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] words [$];
  int          hi_lens [$];
  int          lo_lens [$];
  int          hi_run = 0;
  int          lo_run = 0;
  bit          seen_burst = 0;

  axis2fifo dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .dout          (dout),
    .data_ready    (data_ready),
    .level         (level),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      seen_burst = 0;
      hi_run     = 0;
      lo_run     = 0;
    end else if (data_ready) begin
      words.push_back(dout);
      if (hi_run == 0 && seen_burst) lo_lens.push_back(lo_run);
      hi_run++;
      lo_run = 0;
    end else begin
      if (hi_run != 0) begin
        hi_lens.push_back(hi_run);
        seen_burst = 1;
      end
      hi_run = 0;
      lo_run++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    bit hs;
    int n;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    hs = 0;
    n  = 0;
    while (!hs && n < 200) begin
      hs = s_axis_tready;
      tick();
      n++;
    end
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL handshake data=%h: no tready within 200 cycles", d);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy still %b after 100 cycles, want 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks += 5;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL reset data_ready: got %b want 0", data_ready); end
    if (dout !== 32'h0) begin errors++; $display("FAIL reset dout: got %h want 0", dout); end
    if (level !== 4'd0) begin errors++; $display("FAIL reset level: got %0d want 0", level); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset tready: got %b want 1", s_axis_tready); end
  endtask

  task automatic test_single_burst();
    logic [31:0] exp_w [4];
    int n;
    bit dr_seen;
    exp_w = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) send_beat(exp_w[i], 1'b0);
    s_axis_tvalid = 1'b0;
    checks += 2;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL single early data_ready: got %b want 0", data_ready); end
    if (level !== 4'd4) begin errors++; $display("FAIL single level after 4 beats: got %0d want 4", level); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (data_ready !== 1'b1 || dout !== exp_w[i]) begin
        errors++;
        $display("FAIL single word %0d: got dr=%b dout=%h want dr=1 dout=%h", i, data_ready, dout, exp_w[i]);
      end
    end
    tick();
    checks += 4;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL single burst length: data_ready=%b after 4 words, want 0", data_ready); end
    if (dout !== 32'h0) begin errors++; $display("FAIL single dout after burst: got %h want 0", dout); end
    if (level !== 4'd0) begin errors++; $display("FAIL single level after burst: got %0d want 0", level); end
    if (busy !== 1'b1) begin errors++; $display("FAIL single busy in gap: got %b want 1", busy); end
    n = 0;
    dr_seen = 0;
    while (busy && n < 50) begin
      tick();
      n++;
      if (data_ready) dr_seen = 1;
    end
    checks += 2;
    if (n != GAP) begin errors++; $display("FAIL single gap: busy fell after %0d more cycles, want %0d", n, GAP); end
    if (dr_seen) begin errors++; $display("FAIL single gap data_ready: got 1 during gap want 0"); end
  endtask

  task automatic test_partial_group();
    logic [31:0] exp_w [4];
    bit dr_seen;
    exp_w = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    for (int i = 0; i < 3; i++) send_beat(exp_w[i], 1'b0);
    s_axis_tvalid = 1'b0;
    dr_seen = 0;
    repeat (50) begin
      tick();
      if (data_ready) dr_seen = 1;
    end
    checks += 3;
    if (dr_seen) begin errors++; $display("FAIL partial: data_ready got 1 with 3 words, want 0"); end
    if (level !== 4'd3) begin errors++; $display("FAIL partial level: got %0d want 3", level); end
    if (busy !== 1'b0) begin errors++; $display("FAIL partial busy: got %b want 0", busy); end
    send_beat(exp_w[3], 1'b0);
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (data_ready !== 1'b1 || dout !== exp_w[i]) begin
        errors++;
        $display("FAIL partial word %0d: got dr=%b dout=%h want dr=1 dout=%h", i, data_ready, dout, exp_w[i]);
      end
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int ws, hs0, ls0, n;
    ws  = words.size();
    hs0 = hi_lens.size();
    ls0 = lo_lens.size();
    for (int i = 0; i < 12; i++) send_beat(32'h100 + i, 1'b0);
    s_axis_tvalid = 1'b0;
    checks += 2;
    if (level !== 4'd8) begin errors++; $display("FAIL b2b level after 12 beats: got %0d want 8", level); end
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL b2b tready when full: got %b want 0", s_axis_tready); end
    n = 0;
    while (words.size() - ws < 12 && n < 300) begin
      tick();
      n++;
    end
    wait_idle();
    tick();
    checks++;
    if (words.size() - ws != 12) begin
      errors++;
      $display("FAIL b2b word count: got %0d want 12", words.size() - ws);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (words[ws + i] !== 32'h100 + i) begin
          errors++;
          $display("FAIL b2b word %0d: got %h want %h", i, words[ws + i], 32'h100 + i);
        end
      end
    end
    checks++;
    if (hi_lens.size() - hs0 != 3) begin
      errors++;
      $display("FAIL b2b burst count: got %0d want 3", hi_lens.size() - hs0);
    end
    for (int i = hs0; i < hi_lens.size(); i++) begin
      checks++;
      if (hi_lens[i] != 4) begin errors++; $display("FAIL b2b burst length: got %0d want 4", hi_lens[i]); end
    end
    checks++;
    if (lo_lens.size() - ls0 < 2) begin
      errors++;
      $display("FAIL b2b gap count: got %0d want >=2", lo_lens.size() - ls0);
    end
    for (int i = ls0; i < lo_lens.size(); i++) begin
      checks++;
      if (lo_lens[i] < GAP + 1) begin errors++; $display("FAIL b2b gap length: got %0d want >=%0d", lo_lens[i], GAP + 1); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] exp_w [4];
    exp_w = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
    for (int i = 0; i < 4; i++) send_beat(32'hB1 + i, 1'b0);
    s_axis_tvalid = 1'b0;
    tick();
    tick();
    checks++;
    if (data_ready !== 1'b1 || dout !== 32'hB2) begin
      errors++;
      $display("FAIL rst_mid pre-reset: got dr=%b dout=%h want dr=1 dout=000000b2", data_ready, dout);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 5;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_mid data_ready: got %b want 0", data_ready); end
    if (dout !== 32'h0) begin errors++; $display("FAIL rst_mid dout: got %h want 0", dout); end
    if (level !== 4'd0) begin errors++; $display("FAIL rst_mid level: got %0d want 0", level); end
    if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_mid tready: got %b want 1", s_axis_tready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b want 0", busy); end
    for (int i = 0; i < 4; i++) send_beat(exp_w[i], 1'b0);
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (data_ready !== 1'b1 || dout !== exp_w[i]) begin
        errors++;
        $display("FAIL rst_mid word %0d: got dr=%b dout=%h want dr=1 dout=%h", i, data_ready, dout, exp_w[i]);
      end
    end
    wait_idle();
  endtask

  task automatic test_tlast();
    logic [31:0] exp_w [4];
`ifdef AXIS2FIFO_PAD_ON_TLAST_EN
    exp_w = '{32'h1, 32'h2, 32'h0, 32'h0};
    send_beat(32'h1, 1'b0);
    send_beat(32'h2, 1'b1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    checks += 2;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL pad tready cycle 1: got %b want 0", s_axis_tready); end
    if (level !== 4'd2) begin errors++; $display("FAIL pad level cycle 1: got %0d want 2", level); end
    tick();
    checks++;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL pad tready cycle 2: got %b want 0", s_axis_tready); end
    tick();
    checks += 2;
    if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL pad tready after pad: got %b want 1", s_axis_tready); end
    if (level !== 4'd4) begin errors++; $display("FAIL pad level after pad: got %0d want 4", level); end
`else
    bit dr_seen;
    exp_w = '{32'h1, 32'h2, 32'h3, 32'h4};
    send_beat(32'h1, 1'b0);
    send_beat(32'h2, 1'b1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    checks++;
    if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL tlast tready: got %b want 1", s_axis_tready); end
    dr_seen = 0;
    repeat (20) begin
      tick();
      if (data_ready) dr_seen = 1;
    end
    checks += 2;
    if (dr_seen) begin errors++; $display("FAIL tlast early burst: data_ready got 1 want 0"); end
    if (level !== 4'd2) begin errors++; $display("FAIL tlast level: got %0d want 2", level); end
    send_beat(32'h3, 1'b0);
    send_beat(32'h4, 1'b0);
    s_axis_tvalid = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (data_ready !== 1'b1 || dout !== exp_w[i]) begin
        errors++;
        $display("FAIL tlast word %0d: got dr=%b dout=%h want dr=1 dout=%h", i, data_ready, dout, exp_w[i]);
      end
    end
    wait_idle();
  endtask

  task automatic test_simultaneous();
    int exp_lvl [12];
    int ws, n;
    exp_lvl = '{1, 2, 3, 4, 4, 4, 4, 4, 5, 6, 7, 8};
    ws = words.size();
    for (int i = 0; i < 12; i++) begin
      send_beat(32'hD00 + i, 1'b0);
      checks++;
      if (level !== 4'(exp_lvl[i])) begin
        errors++;
        $display("FAIL simul level after beat %0d: got %0d want %0d", i, level, exp_lvl[i]);
      end
    end
    s_axis_tvalid = 1'b0;
    n = 0;
    while (words.size() - ws < 12 && n < 300) begin
      tick();
      n++;
    end
    wait_idle();
    checks += 2;
    if (level !== 4'd0) begin errors++; $display("FAIL simul final level: got %0d want 0", level); end
    if (words.size() - ws != 12) begin
      errors++;
      $display("FAIL simul word count: got %0d want 12", words.size() - ws);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (words[ws + i] !== 32'hD00 + i) begin
          errors++;
          $display("FAIL simul word %0d: got %h want %h", i, words[ws + i], 32'hD00 + i);
        end
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    test_reset();
    test_single_burst();
    test_partial_group();
    test_back_to_back();
    test_reset_mid_burst();
    test_tlast();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
